// File: rtl/ddr_tx_pkg.sv
// Shared types and constants for the DDR transmit serializer.
// Kept small so both the holding slot and the top can import it.
package ddr_tx_pkg;

  localparam int PAIR_W = 2;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
  localparam logic [1:0] IDLE_PAT_DEFAULT  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA
  } tx_state_t;

  // A one-pair word still needs a one-bit counter.
  function automatic int cnt_width(input int pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

endpackage

// File: rtl/tx_hold_slot.sv
// Single-entry holding register in front of the shifter.
// A new accept on the same edge as a load keeps the slot full with the new word.
module tx_hold_slot #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] word,
  input  logic              word_valid,
  input  logic              load,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              ready
);

  logic [WORD_W-1:0] data_reg;
  logic              valid_reg;
  logic              accept;

  assign ready  = !valid_reg && enable;
  assign accept = word_valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        data_reg  <= word;
        valid_reg <= 1'b1;
      end else if (load) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/ddr_tx_serializer.sv
// Serialises parallel words into 2-bit pairs for the SDR-to-DDR output stage,
// prefixing each burst with one sync word and driving an idle pattern between bursts.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter logic [1:0]        IDLE_PAT  = IDLE_PAT_DEFAULT,
  parameter int                COUNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               enable,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  output logic [1:0]         pair_o,
  output logic               pair_en_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] words_sent_o
);

  localparam int PAIRS = WORD_W / PAIR_W;
  localparam int CNT_W = cnt_width(PAIRS);

  localparam logic [WORD_W-1:0] IDLE_FILL = {PAIRS{IDLE_PAT}};
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PAIRS - 1);

  tx_state_t          state_reg;
  logic [WORD_W-1:0]  shift_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               pair_en_reg;
  logic [COUNT_W-1:0] words_sent_reg;

  logic [WORD_W-1:0]  hold_data;
  logic               hold_valid;
  logic               hold_load;

  // The slot empties only when the shifter takes its word at the end of a word time.
  assign hold_load = (state_reg != ST_IDLE) && (cnt_reg == '0) && hold_valid;

  tx_hold_slot #(
    .WORD_W (WORD_W)
  ) u_hold (
    .clk        (clk_i),
    .rst        (reset),
    .enable     (enable),
    .word       (word_i),
    .word_valid (word_valid_i),
    .load       (hold_load),
    .data       (hold_data),
    .valid      (hold_valid),
    .ready      (word_ready_o)
  );

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= IDLE_FILL;
      cnt_reg        <= '0;
      pair_en_reg    <= 1'b0;
      words_sent_reg <= '0;
    end else if (enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (hold_valid) begin
            shift_reg   <= SYNC_WORD;
            cnt_reg     <= LAST_CNT;
            pair_en_reg <= 1'b1;
            state_reg   <= ST_SYNC;
          end
        end
        default: begin
          if (cnt_reg != '0) begin
            shift_reg <= shift_reg >> PAIR_W;
            cnt_reg   <= cnt_reg - 1'b1;
          end else begin
            if (state_reg == ST_DATA) begin
              words_sent_reg <= words_sent_reg + 1'b1;
            end
            // A sync word always has a payload word waiting behind it.
            if (hold_valid) begin
              shift_reg <= hold_data;
              cnt_reg   <= LAST_CNT;
              state_reg <= ST_DATA;
            end else begin
              shift_reg   <= IDLE_FILL;
              pair_en_reg <= 1'b0;
              state_reg   <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign pair_o       = shift_reg[1:0];
  assign pair_en_o    = pair_en_reg;
  assign busy_o       = (state_reg != ST_IDLE) || hold_valid;
  assign words_sent_o = words_sent_reg;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Randomised and directed checks of ddr_tx_serializer against a queue-based model
// of the pair stream: each accepted word becomes sync pairs plus data pairs.
module tb_ddr_tx_serializer;

  localparam int WORD_W  = 8;
  localparam int COUNT_W = 4;
  localparam int PAIRS   = WORD_W / 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic               clk_i = 1'b0;
  logic               reset;
  logic               enable;
  logic [WORD_W-1:0]  word_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic [1:0]         pair_o;
  logic               pair_en_o;
  logic               busy_o;
  logic [COUNT_W-1:0] words_sent_o;

  always #5 clk_i = ~clk_i;

  ddr_tx_serializer #(
    .WORD_W  (WORD_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .enable       (enable),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .pair_o       (pair_o),
    .pair_en_o    (pair_en_o),
    .busy_o       (busy_o),
    .words_sent_o (words_sent_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of pairs still to appear on pair_o (front = shown now).
  // Bit 2 of an entry marks the final pair of a payload word.
  int         stream[$];
  logic [7:0] m_hold;
  bit         m_hold_full;
  int         m_sent;

  function automatic void model_reset();
    stream.delete();
    m_hold_full = 1'b0;
    m_sent      = 0;
  endfunction

  function automatic void push_word(input logic [7:0] w, input bit is_data);
    for (int k = 0; k < PAIRS; k++) begin
      int e;
      e = int'((w >> (2 * k)) & 8'h03);
      if (is_data && k == PAIRS - 1) e = e | 4;
      stream.push_back(e);
    end
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] w);
    bit acc;
    acc = v && !m_hold_full;
    if (stream.size() == 0) begin
      if (m_hold_full) push_word(SYNC, 1'b0);
    end else begin
      int e;
      e = stream.pop_front();
      if ((e & 4) != 0) m_sent = (m_sent + 1) % (1 << COUNT_W);
      if (stream.size() == 0 && m_hold_full) begin
        push_word(m_hold, 1'b1);
        m_hold_full = 1'b0;
      end
    end
    if (acc) begin
      m_hold      = w;
      m_hold_full = 1'b1;
    end
  endfunction

  task automatic check_all();
    int exp_pair;
    bit exp_en;
    exp_en   = (stream.size() != 0);
    exp_pair = exp_en ? (stream[0] & 3) : 0;
    check_eq("pair_o",       32'(pair_o),       32'(exp_pair));
    check_eq("pair_en_o",    32'(pair_en_o),    32'(exp_en));
    check_eq("word_ready_o", 32'(word_ready_o), 32'(!m_hold_full && enable));
    check_eq("busy_o",       32'(busy_o),       32'(exp_en || m_hold_full));
    check_eq("words_sent_o", 32'(words_sent_o), 32'(m_sent));
  endtask

  bit acc;

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit v, input logic [7:0] w, input bit en, output bit accepted);
    word_valid_i = v;
    word_i       = w;
    enable       = en;
    accepted     = en && v && !m_hold_full;
    @(posedge clk_i);
    if (en) model_edge(v, w);
    #1;
    check_all();
    if (accepted) $display("word %02h accepted at %0t", w, $time);
  endtask

  task automatic do_reset();
    word_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  int         seq[$];
  int         exp3c[8] = '{1, 1, 2, 2, 0, 3, 3, 0};
  logic [7:0] b2b[3]   = '{8'hFF, 8'h00, 8'h81};
  int         idx, en_cycles, bursts;
  bit         prev_en;

  initial begin
    reset = 1'b1; enable = 1'b0; word_valid_i = 1'b0; word_i = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk_i); #1;
    reset = 1'b0;
    check_eq("ready_en_low", 32'(word_ready_o), 32'd0);
    enable = 1'b1;
    #1;
    check_eq("ready_after_reset", 32'(word_ready_o), 32'd1);

    // Single word 8'h3C: sync A5 then 3C, first sync pair after E1
    step(1'b1, 8'h3C, 1'b1, acc);
    check_eq("e0_no_pair_en", 32'(pair_en_o), 32'd0);
    seq.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b1, acc);
      if (i == 0) check_eq("e1_first_sync", {30'd0, pair_o}, 32'd1);
      if (pair_en_o) seq.push_back(int'(pair_o));
    end
    check_eq("3c_len", 32'(seq.size()), 32'd8);
    for (int i = 0; i < 8 && i < seq.size(); i++) check_eq("3c_pair", 32'(seq[i]), 32'(exp3c[i]));
    check_eq("3c_sent", 32'(words_sent_o), 32'd1);

    // Back-to-back words with valid held high: one sync, then 12 gapless data pairs
    do_reset();
    idx = 0; en_cycles = 0; bursts = 0; prev_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(idx < 3, b2b[idx < 3 ? idx : 2], 1'b1, acc);
      if (acc) idx++;
      if (pair_en_o) en_cycles++;
      if (pair_en_o && !prev_en) bursts++;
      prev_en = pair_en_o;
    end
    check_eq("b2b_accepted", 32'(idx), 32'd3);
    check_eq("b2b_en_cycles", 32'(en_cycles), 32'd16);
    check_eq("b2b_bursts", 32'(bursts), 32'd1);
    check_eq("b2b_sent", 32'(words_sent_o), 32'd3);

    // Stall after second data pair of 8'h3C
    do_reset();
    step(1'b1, 8'h3C, 1'b1, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, acc);
    check_eq("stall_pre", {30'd0, pair_o}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 1'b0, acc);
      check_eq("stall_pair", {30'd0, pair_o}, 32'd3);
      check_eq("stall_ready", 32'(word_ready_o), 32'd0);
    end
    step(1'b0, 8'h00, 1'b1, acc);
    check_eq("resume_p2", {30'd0, pair_o}, 32'd3);
    step(1'b0, 8'h00, 1'b1, acc);
    check_eq("resume_p3", {30'd0, pair_o}, 32'd0);
    check_eq("resume_p3_en", 32'(pair_en_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, acc);
    check_eq("resume_idle_en", 32'(pair_en_o), 32'd0);
    check_eq("resume_sent", 32'(words_sent_o), 32'd1);

    // Gap between bursts gives two sync prefixes
    do_reset();
    bursts = 0; prev_en = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == 0)       step(1'b1, 8'h12, 1'b1, acc);
      else if (i == 11) step(1'b1, 8'h34, 1'b1, acc);
      else              step(1'b0, 8'h00, 1'b1, acc);
      if (pair_en_o && !prev_en) bursts++;
      prev_en = pair_en_o;
    end
    check_eq("gap_bursts", 32'(bursts), 32'd2);
    check_eq("gap_sent", 32'(words_sent_o), 32'd2);

    // Counter wrap with a 4-bit count: 17 words leaves 1
    do_reset();
    idx = 0;
    for (int i = 0; i < 120; i++) begin
      step(idx < 17, 8'(idx * 37 + 5), 1'b1, acc);
      if (acc) idx++;
    end
    check_eq("wrap_accepted", 32'(idx), 32'd17);
    check_eq("wrap_sent", 32'(words_sent_o), 32'd1);

    // Random traffic with enable stalls and one mid-stream reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step(($urandom % 3) != 0, 8'($urandom), ($urandom_range(0, 9) != 0), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
